// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register-file writeback path.
//   NUM_REGS / XLEN / ADDR_W : default geometry of the DSP register file
//   wb_src_e                 : which producer supplied a registered writeback
//   rr_e                     : round-robin owner between MAC and load
//   REG_DSP0..2              : indices of the three DSP registers (16-18)
package regfile_writeback_pkg;

    localparam int unsigned NUM_REGS = 19;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned ADDR_W   = 5;

    localparam int unsigned REG_DSP0 = 16;
    localparam int unsigned REG_DSP1 = 17;
    localparam int unsigned REG_DSP2 = 18;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MAC = 2'd1,
        SRC_LD  = 2'd2
    } wb_src_e;

    typedef enum logic {
        RR_MAC = 1'b0,
        RR_LD  = 1'b1
    } rr_e;

endpackage

// File: rtl/regfile_writeback_scoreboard.sv
// Pending multi-cycle write scoreboard.
//   clk, rst         : clock, synchronous active-high reset
//   alloc_en/rd      : issue stage dispatched a MAC/load op targeting rd
//   clr_en/rd        : a MAC/load writeback is landing in the register file
//   busy             : per-register pending-write flags (bit 0 always 0)
//   alloc_err        : combinational, alloc_rd is outside the register file
module wb_scoreboard
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned NUM_REGS = regfile_writeback_pkg::NUM_REGS,
    parameter int unsigned ADDR_W   = regfile_writeback_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_en,
    input  logic [ADDR_W-1:0]   alloc_rd,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_rd,
    output logic [NUM_REGS-1:0] busy,
    output logic                alloc_err
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;
    logic                alloc_ok;

    assign alloc_err = alloc_en && (32'(alloc_rd) >= NUM_REGS);
    assign alloc_ok  = alloc_en && !alloc_err && (alloc_rd != '0);

    // Set is ORed in after the clear so a re-allocation on the clearing
    // edge keeps the register busy for the newer op.
    always_comb begin
        busy_next = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            busy_next[i] = (alloc_ok && (alloc_rd == ADDR_W'(i)))
                        || (busy_q[i] && !(clr_en && (clr_rd == ADDR_W'(i))));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter for the DSP register file write port.
//   clk, rst             : clock, synchronous active-high reset
//   alu_*                : ALU result, always accepted, highest priority
//   mac_* / ld_*         : MAC and load results, valid/ready, round-robin
//   alloc_en/alloc_rd    : issue-stage allocation of a multi-cycle write
//   wb_en/wb_rd/wb_data  : registered register-file write port
//   busy                 : per-register pending multi-cycle write
//   addr_err             : sticky out-of-range destination flag
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned NUM_REGS = regfile_writeback_pkg::NUM_REGS,
    parameter int unsigned XLEN     = regfile_writeback_pkg::XLEN,
    parameter int unsigned ADDR_W   = regfile_writeback_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [XLEN-1:0]     alu_data,
    input  logic                mac_valid,
    output logic                mac_ready,
    input  logic [ADDR_W-1:0]   mac_rd,
    input  logic [XLEN-1:0]     mac_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [ADDR_W-1:0]   ld_rd,
    input  logic [XLEN-1:0]     ld_data,
    input  logic                alloc_en,
    input  logic [ADDR_W-1:0]   alloc_rd,
    output logic                wb_en,
    output logic [ADDR_W-1:0]   wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic [NUM_REGS-1:0] busy,
    output logic                addr_err
);

    rr_e                rr_ptr;
    wb_src_e            wb_src;

    logic               sel_valid;
    logic [ADDR_W-1:0]  sel_rd;
    logic [XLEN-1:0]    sel_data;
    wb_src_e            sel_src;
    logic               sel_bad_rd;
    logic               alloc_err;
    logic               clr_en;

    assign mac_ready = !rst && !alu_valid && mac_valid
                    && (!ld_valid || rr_ptr == RR_MAC);
    assign ld_ready  = !rst && !alu_valid && ld_valid
                    && (!mac_valid || rr_ptr == RR_LD);

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        sel_src   = SRC_ALU;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
            sel_src   = SRC_ALU;
        end else if (mac_ready) begin
            sel_valid = 1'b1;
            sel_rd    = mac_rd;
            sel_data  = mac_data;
            sel_src   = SRC_MAC;
        end else if (ld_ready) begin
            sel_valid = 1'b1;
            sel_rd    = ld_rd;
            sel_data  = ld_data;
            sel_src   = SRC_LD;
        end
    end

    assign sel_bad_rd = 32'(sel_rd) >= NUM_REGS;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_src   <= SRC_ALU;
            rr_ptr   <= RR_MAC;
            addr_err <= 1'b0;
        end else begin
            wb_en <= sel_valid && !sel_bad_rd && (sel_rd != '0);
            if (sel_valid) begin
                wb_rd   <= sel_rd;
                wb_data <= sel_data;
                wb_src  <= sel_src;
            end
            if (mac_ready || ld_ready) begin
                rr_ptr <= mac_ready ? RR_LD : RR_MAC;
            end
            if ((sel_valid && sel_bad_rd) || alloc_err) begin
                addr_err <= 1'b1;
            end
        end
    end

    // Clear fires while the write is on the port, i.e. on the same edge
    // the register file captures it.
    assign clr_en = wb_en && (wb_src == SRC_MAC || wb_src == SRC_LD);

    wb_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .alloc_en  (alloc_en),
        .alloc_rd  (alloc_rd),
        .clr_en    (clr_en),
        .clr_rd    (wb_rd),
        .busy      (busy),
        .alloc_err (alloc_err)
    );

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mac_valid;
    logic        mac_ready;
    logic [4:0]  mac_rd;
    logic [31:0] mac_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        alloc_en;
    logic [4:0]  alloc_rd;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [18:0] busy;
    logic        addr_err;

    int unsigned checks = 0;
    int unsigned passed = 0;

    regfile_writeback #(
        .NUM_REGS (19),
        .XLEN     (32),
        .ADDR_W   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mac_valid (mac_valid),
        .mac_ready (mac_ready),
        .mac_rd    (mac_rd),
        .mac_data  (mac_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .alloc_en  (alloc_en),
        .alloc_rd  (alloc_rd),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .busy      (busy),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and sample 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mac_valid = 1'b0; mac_rd = '0; mac_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
        alloc_en  = 1'b0; alloc_rd = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        mac_valid = 1'b1; mac_rd = 5'd4;
        ld_valid  = 1'b1; ld_rd  = 5'd6;
        tick();
        tick();
        checks++;
        if ({mac_ready, ld_ready} !== 2'b00)
            $display("FAIL reset_ready got %b exp 00", {mac_ready, ld_ready});
        else passed++;
        checks++;
        if ({wb_en, wb_rd, wb_data, busy, addr_err} !== '0)
            $display("FAIL reset_outputs got en=%b rd=%0d data=%h busy=%h err=%b exp all 0",
                     wb_en, wb_rd, wb_data, busy, addr_err);
        else passed++;
        rst = 1'b0;
        idle();
        tick();
        checks++;
        if ({wb_en, busy, addr_err} !== '0)
            $display("FAIL idle_outputs got en=%b busy=%h err=%b exp 0", wb_en, busy, addr_err);
        else passed++;
    endtask

    task automatic test_alloc();
        alloc_en = 1'b1; alloc_rd = 5'd5;
        tick();
        alloc_en = 1'b0;
        checks++;
        if (busy !== 19'h00020) $display("FAIL alloc_busy got %h exp 00020", busy);
        else passed++;
    endtask

    task automatic test_alu_priority();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
        mac_valid = 1'b1; mac_rd = 5'd4; mac_data = 32'h1111_2222;
        #1;
        checks++;
        if (mac_ready !== 1'b0) $display("FAIL alu_blocks_mac got %b exp 0", mac_ready);
        else passed++;
        tick();
        alu_valid = 1'b0;
        #1;
        checks++;
        if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd3, 32'hDEADBEEF})
            $display("FAIL alu_wb got en=%b rd=%0d data=%h exp 1 3 deadbeef", wb_en, wb_rd, wb_data);
        else passed++;
        checks++;
        if (mac_ready !== 1'b1) $display("FAIL mac_ready_after_alu got %b exp 1", mac_ready);
        else passed++;
        tick();
        mac_valid = 1'b0;
        checks++;
        if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd4, 32'h1111_2222})
            $display("FAIL mac_wb got en=%b rd=%0d data=%h exp 1 4 11112222", wb_en, wb_rd, wb_data);
        else passed++;
        tick();
        checks++;
        if ({wb_en, busy} !== {1'b0, 19'h00020})
            $display("FAIL after_mac got en=%b busy=%h exp 0 00020", wb_en, busy);
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [4:0] exp_rd [4] = '{5'd4, 5'd6, 5'd4, 5'd6};
        do_reset();
        mac_valid = 1'b1; mac_rd = 5'd4; mac_data = 32'hAAAA_0001;
        ld_valid  = 1'b1; ld_rd  = 5'd6; ld_data  = 32'hBBBB_0002;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({mac_ready, ld_ready} !== ((exp_rd[i] == 5'd4) ? 2'b10 : 2'b01))
                $display("FAIL rr_grant%0d got %b exp %b", i, {mac_ready, ld_ready},
                         (exp_rd[i] == 5'd4) ? 2'b10 : 2'b01);
            else passed++;
            tick();
            checks++;
            if ({wb_en, wb_rd} !== {1'b1, exp_rd[i]})
                $display("FAIL rr_wb%0d got en=%b rd=%0d exp 1 %0d", i, wb_en, wb_rd, exp_rd[i]);
            else passed++;
        end
        idle();
        tick();
    endtask

    task automatic test_busy_clear();
        // Set-wins case: re-allocation on the clearing edge.
        alloc_en = 1'b1; alloc_rd = 5'd7;
        tick();
        alloc_en = 1'b0;
        mac_valid = 1'b1; mac_rd = 5'd7; mac_data = 32'h7777;
        tick();
        mac_valid = 1'b0;
        alloc_en = 1'b1; alloc_rd = 5'd7;
        tick();
        alloc_en = 1'b0;
        checks++;
        if (busy[7] !== 1'b1) $display("FAIL set_wins got %b exp 1", busy[7]);
        else passed++;
        // Ordinary clear: still busy during N+1, clear after edge N+1.
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h8888;
        tick();
        ld_valid = 1'b0;
        checks++;
        if ({wb_en, busy[7]} !== 2'b11) $display("FAIL busy_during_wb got en=%b busy7=%b exp 1 1", wb_en, busy[7]);
        else passed++;
        tick();
        checks++;
        if (busy !== '0) $display("FAIL busy_cleared got %h exp 0", busy);
        else passed++;
        // ALU writes do not clear busy.
        alloc_en = 1'b1; alloc_rd = 5'd9;
        tick();
        alloc_en = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9;
        tick();
        alu_valid = 1'b0;
        tick();
        checks++;
        if (busy !== 19'h00200) $display("FAIL alu_keeps_busy got %h exp 00200", busy);
        else passed++;
    endtask

    task automatic test_rd_zero();
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h1234;
        #1;
        checks++;
        if (ld_ready !== 1'b1) $display("FAIL rd0_ready got %b exp 1", ld_ready);
        else passed++;
        tick();
        ld_valid = 1'b0;
        checks++;
        if ({wb_en, busy, addr_err} !== {1'b0, 19'h00200, 1'b0})
            $display("FAIL rd0_wb got en=%b busy=%h err=%b exp 0 00200 0", wb_en, busy, addr_err);
        else passed++;
    endtask

    task automatic test_addr_err();
        mac_valid = 1'b1; mac_rd = 5'd20; mac_data = 32'h20;
        #1;
        checks++;
        if (mac_ready !== 1'b1) $display("FAIL bad_rd_ready got %b exp 1", mac_ready);
        else passed++;
        tick();
        mac_valid = 1'b0;
        checks++;
        if ({wb_en, addr_err} !== 2'b01) $display("FAIL bad_rd_wb got en=%b err=%b exp 0 1", wb_en, addr_err);
        else passed++;
        tick();
        tick();
        checks++;
        if (addr_err !== 1'b1) $display("FAIL err_sticky got %b exp 1", addr_err);
        else passed++;
        do_reset();
        #1;
        checks++;
        if (addr_err !== 1'b0) $display("FAIL err_reset got %b exp 0", addr_err);
        else passed++;
        alloc_en = 1'b1; alloc_rd = 5'd25;
        tick();
        alloc_en = 1'b0;
        checks++;
        if ({addr_err, busy} !== {1'b1, 19'h0}) $display("FAIL alloc_bad got err=%b busy=%h exp 1 0", addr_err, busy);
        else passed++;
        // Highest DSP register is in range.
        do_reset();
        alloc_en = 1'b1; alloc_rd = 5'd18;
        tick();
        alloc_en = 1'b0;
        checks++;
        if ({addr_err, busy} !== {1'b0, 19'h40000}) $display("FAIL alloc_r18 got err=%b busy=%h exp 0 40000", addr_err, busy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_en = 1'b1; alloc_rd = 5'd3;
        mac_valid = 1'b1; mac_rd = 5'd11; mac_data = 32'h11;
        tick();
        alloc_en = 1'b0;
        // rr_ptr is now LD; reset while a MAC handshake is offered.
        mac_rd = 5'd5; mac_data = 32'h55;
        rst = 1'b1;
        #1;
        checks++;
        if (mac_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", mac_ready);
        else passed++;
        tick();
        rst = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h66;
        #1;
        checks++;
        if ({wb_en, busy} !== {1'b0, 19'h0}) $display("FAIL rst_drop got en=%b busy=%h exp 0 0", wb_en, busy);
        else passed++;
        checks++;
        if ({mac_ready, ld_ready} !== 2'b10) $display("FAIL rst_rr got %b exp 10", {mac_ready, ld_ready});
        else passed++;
        tick();
        idle();
        checks++;
        if ({wb_en, wb_rd, wb_data} !== {1'b1, 5'd5, 32'h55})
            $display("FAIL post_rst_wb got en=%b rd=%0d data=%h exp 1 5 55", wb_en, wb_rd, wb_data);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_alu_priority();
        test_round_robin();
        test_busy_clear();
        test_rd_zero();
        test_addr_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
